// File: rtl/pipe_adder_parity_if.sv
// Handshake and result bundle for pipe_adder_parity.
// The master side drives operands and out_ready; the slave side is the adder.
interface pipe_adder_parity_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             par_even;
    logic             par_odd;
    logic [CNT_W-1:0] res_cnt;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, par_even, par_odd, res_cnt
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, par_even, par_odd, res_cnt
    );
endinterface

// File: rtl/pipe_adder_parity.sv
// Pipelined add/subtract with segmented carry chain, one SEG-bit segment per stage,
// followed by a flag/parity output register; global stall on output backpressure.
module pipe_adder_parity #(
    parameter int WIDTH = 8,
    parameter int SEG   = 4,
    parameter int CNT_W = 8
) (
    input  logic               clock,
    input  logic               reset,
    pipe_adder_parity_if.slave io
);
    localparam int N = WIDTH / SEG;

    logic             vld_p [1:N];
    logic             c_p   [1:N];
    logic [WIDTH-1:0] a_p   [1:N];
    logic [WIDTH-1:0] b_p   [1:N];
    logic [WIDTH-1:0] s_p   [1:N];

    logic             src_v   [1:N];
    logic             src_c   [1:N];
    logic [WIDTH-1:0] src_a   [1:N];
    logic [WIDTH-1:0] src_b   [1:N];
    logic [WIDTH-1:0] src_s   [1:N];
    logic [SEG:0]     seg_sum [1:N];
    logic [WIDTH-1:0] nxt_s   [1:N];

    logic en;

    function automatic logic even_bit(input logic [WIDTH-1:0] v);
        return ^v;
    endfunction

    // Carry into the MSB is recovered as sum^a^b at that bit position.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                        input logic s_msb, input logic c_out);
        return (s_msb ^ a_msb ^ b_msb) ^ c_out;
    endfunction

    assign en          = !io.out_valid || io.out_ready;
    assign io.in_ready = en;

    always_comb begin
        src_v[1] = io.in_valid;
        src_a[1] = io.a;
        src_b[1] = io.sub ? ~io.b : io.b;
        src_c[1] = io.sub | io.cin;
        src_s[1] = '0;
        for (int k = 2; k <= N; k++) begin
            src_v[k] = vld_p[k-1];
            src_a[k] = a_p[k-1];
            src_b[k] = b_p[k-1];
            src_c[k] = c_p[k-1];
            src_s[k] = s_p[k-1];
        end
        for (int k = 1; k <= N; k++) begin
            seg_sum[k] = {1'b0, src_a[k][(k-1)*SEG +: SEG]}
                       + {1'b0, src_b[k][(k-1)*SEG +: SEG]}
                       + {{SEG{1'b0}}, src_c[k]};
            nxt_s[k] = src_s[k];
            nxt_s[k][(k-1)*SEG +: SEG] = seg_sum[k][SEG-1:0];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 1; k <= N; k++) begin
                vld_p[k] <= 1'b0;
                c_p[k]   <= 1'b0;
                a_p[k]   <= '0;
                b_p[k]   <= '0;
                s_p[k]   <= '0;
            end
            io.out_valid <= 1'b0;
            io.sum       <= '0;
            io.cout      <= 1'b0;
            io.ovf       <= 1'b0;
            io.par_even  <= 1'b0;
            io.par_odd   <= 1'b0;
            io.res_cnt   <= '0;
        end else begin
            if (en) begin
                // segment stages 1..N: stage k resolves segment k-1
                for (int k = 1; k <= N; k++) begin
                    vld_p[k] <= src_v[k];
                    c_p[k]   <= seg_sum[k][SEG];
                    a_p[k]   <= src_a[k];
                    b_p[k]   <= src_b[k];
                    s_p[k]   <= nxt_s[k];
                end
                // output register: final sum with its flags and parity
                io.out_valid <= vld_p[N];
                io.sum       <= s_p[N];
                io.cout      <= c_p[N];
                io.ovf       <= signed_ovf(a_p[N][WIDTH-1], b_p[N][WIDTH-1],
                                           s_p[N][WIDTH-1], c_p[N]);
                io.par_even  <= even_bit(s_p[N]);
                io.par_odd   <= ~even_bit(s_p[N]);
            end
            if (io.out_valid && io.out_ready) begin
                io.res_cnt <= io.res_cnt + CNT_W'(1);
            end
        end
    end
endmodule
